// File: rtl/alu_sched_pkg.sv
// Shared opcode constants, FSM state encoding and helpers for the ALU request scheduler.
package alu_sched_pkg;

  localparam logic [3:0] ADD     = 4'd0;
  localparam logic [3:0] SUB     = 4'd1;
  localparam logic [3:0] AND     = 4'd2;
  localparam logic [3:0] OR      = 4'd3;
  localparam logic [3:0] SGE     = 4'd4;
  localparam logic [3:0] SGT     = 4'd5;
  localparam logic [3:0] OPC_MAX = 4'd5;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OPC_MAX;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational requester arbiter: one-hot grant plus encoded index.
// ALU_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

`ifdef ALU_SCHED_FIXED_PRIO_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Descending scan so the lowest requesting index is written last and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = NUM_REQ'(1) << i;
        grant_idx = ID_W'(i);
      end
    end
  end
`else
  int unsigned idx;

  // Descending scan of the rotated order so the first hit from rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (32'(rr_ptr) + 32'(k)) % NUM_REQ;
      if (((req >> idx) & NUM_REQ'(1)) != '0) begin
        grant     = NUM_REQ'(1) << idx;
        grant_idx = ID_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one external ALU among NUM_REQ requesters with a registered, ID-tagged response.
// ALU_SCHED_FIXED_PRIO_EN switches arbitration to fixed priority and drops the rr pointer.
module alu_req_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*4-1:0]     req_opcode,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [3:0]               alu_opcode,
  output logic [WIDTH-1:0]         alu_input1,
  output logic [WIDTH-1:0]         alu_input2,
  output logic [4:0]               alu_shift,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  input  logic                     alu_sign,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic                     rsp_sign,
  output logic                     rsp_err
);
  import alu_sched_pkg::*;

  state_e             state_q;
  logic [3:0]         opc_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [ID_W-1:0]    id_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    rr_ptr;
  logic [3:0]         sel_opc;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               accept;

  alu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept    = (state_q == StIdle) && (|req_valid);
  assign req_ready = (state_q == StIdle) ? grant : '0;

  assign sel_opc = 4'(req_opcode >> (4 * grant_idx));
  assign sel_a   = WIDTH'(req_a >> (WIDTH * grant_idx));
  assign sel_b   = WIDTH'(req_b >> (WIDTH * grant_idx));

  // ALU is fed only from the operand registers, so it sees stable inputs for all of EXEC.
  assign alu_opcode = opc_q;
  assign alu_input1 = a_q;
  assign alu_input2 = b_q;
  assign alu_shift  = 5'd0;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr_q;
  assign rr_ptr = rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      if (32'(grant_idx) == NUM_REQ - 1) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= grant_idx + ID_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      opc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_sign   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            opc_q   <= sel_opc;
            a_q     <= sel_a;
            b_q     <= sel_b;
            id_q    <= grant_idx;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          if (is_legal_op(opc_q)) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
            rsp_sign   <= alu_sign;
            rsp_err    <= 1'b0;
          end else begin
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_err    <= 1'b1;
          end
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed self-checking bench for alu_req_scheduler; the bench itself models the external ALU.
module tb_alu_req_scheduler;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [15:0]  req_opcode;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   alu_opcode;
  logic [31:0]  alu_input1;
  logic [31:0]  alu_input2;
  logic [4:0]   alu_shift;
  logic [31:0]  alu_result;
  logic         alu_carry;
  logic         alu_zero;
  logic         alu_sign;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_sign;
  logic         rsp_err;

  logic [3:0]  opc [4];
  logic [31:0] opa [4];
  logic [31:0] opb [4];

  int errors = 0;
  int checks = 0;

  assign req_opcode = {opc[3], opc[2], opc[1], opc[0]};
  assign req_a      = {opa[3], opa[2], opa[1], opa[0]};
  assign req_b      = {opb[3], opb[2], opb[1], opb[0]};

  alu_req_scheduler #(
    .NUM_REQ (4),
    .WIDTH   (32),
    .ID_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_opcode (alu_opcode),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .alu_shift  (alu_shift),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .alu_sign   (alu_sign),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_sign   (rsp_sign),
    .rsp_err    (rsp_err)
  );

  // External ALU stand-in; illegal opcodes return junk so dropped-output handling is visible.
  always_comb begin
    logic [32:0] t;
    t = '0;
    alu_carry = 1'b0;
    case (alu_opcode)
      4'd0: t = {1'b0, alu_input1} + {1'b0, alu_input2};
      4'd1: t = {1'b0, alu_input1} - {1'b0, alu_input2};
      4'd2: t = {1'b0, alu_input1 & alu_input2};
      4'd3: t = {1'b0, alu_input1 | alu_input2};
      4'd4: t = ($signed(alu_input1) >= $signed(alu_input2)) ? 33'd1 : 33'd0;
      4'd5: t = ($signed(alu_input1) >  $signed(alu_input2)) ? 33'd1 : 33'd0;
      default: t = {1'b1, 32'hDEADBEEF};
    endcase
    alu_result = t[31:0];
    alu_carry  = t[32];
    alu_zero   = (t[31:0] == 32'd0);
    alu_sign   = t[31];
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    opc[i]    = op;
    opa[i]    = a;
    opb[i]    = b;
    req_valid = req_valid | (4'b0001 << i);
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        g = req_ready;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    logic [3:0] exp_g;
    int         lat;

    for (int i = 0; i < 4; i++) begin
      opc[i] = '0;
      opa[i] = '0;
      opb[i] = '0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_id", rsp_id, 2'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_alu_in1", alu_input1, 32'd0);
    check("rst_alu_shift", alu_shift, 5'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request: ADD 0xFFFFFFFF + 1 from requester 2
    set_req(2, 4'd0, 32'hFFFF_FFFF, 32'd1);
    #1 check("single_ready", req_ready, 4'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    check("single_ready_exec", req_ready, 4'b0000);
    check("single_alu_in1", alu_input1, 32'hFFFF_FFFF);
    check("single_alu_in2", alu_input2, 32'd1);
    wait_rsp(lat);
    check("single_latency", lat, 2);
    check("single_id", rsp_id, 2'd2);
    check("single_result", rsp_result, 32'd0);
    check("single_carry", rsp_carry, 1'b1);
    check("single_zero", rsp_zero, 1'b1);
    check("single_sign", rsp_sign, 1'b0);
    check("single_err", rsp_err, 1'b0);

    // Contention from a fresh rr pointer: SUB 5-3 on all four
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 4'd1, 32'd5, 32'd3);
    for (int n = 0; n < 5; n++) begin
      exp_g = FIXED ? 4'b0001 : (4'b0001 << (n % 4));
      wait_grant(g);
      check("cont_grant", g, exp_g);
      wait_rsp(lat);
      check("cont_latency", lat, 2);
      check("cont_id", rsp_id, FIXED ? 2'd0 : 2'(n % 4));
      check("cont_result", rsp_result, 32'd2);
    end

    // Backpressure: requester 1 served, requester 3 must wait for the handshake
    @(posedge clk);
    #1 req_valid = '0;
    rsp_ready = 1'b0;
    set_req(1, 4'd3, 32'h0000_00F0, 32'h0000_000F);
    set_req(3, 4'd2, 32'h0000_00F0, 32'h0000_000F);
    wait_grant(g);
    check("bp_grant1", g, 4'b0010);
    @(posedge clk);
    #1 req_valid = req_valid & ~4'b0010;
    wait_rsp(lat);
    check("bp_id1", rsp_id, 2'd1);
    check("bp_result1", rsp_result, 32'h0000_00FF);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1'b1);
      check("bp_hold_id", rsp_id, 2'd1);
      check("bp_hold_result", rsp_result, 32'h0000_00FF);
      check("bp_no_ready", req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    wait_grant(g);
    check("bp_grant3", g, 4'b1000);
    check("bp_valid_cleared", rsp_valid, 1'b0);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(lat);
    check("bp_id3", rsp_id, 2'd3);
    check("bp_result3", rsp_result, 32'd0);
    check("bp_zero3", rsp_zero, 1'b1);

    // Illegal opcode 9 from requester 1
    @(posedge clk);
    #1 set_req(1, 4'd9, 32'd5, 32'd3);
    wait_grant(g);
    check("ill_grant", g, 4'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(lat);
    check("ill_err", rsp_err, 1'b1);
    check("ill_result", rsp_result, 32'd0);
    check("ill_carry", rsp_carry, 1'b0);
    check("ill_zero", rsp_zero, 1'b0);
    check("ill_sign", rsp_sign, 1'b0);
    check("ill_id", rsp_id, 2'd1);

    // Reset while in EXEC drops the op and rewinds the pointer
    @(posedge clk);
    #1 set_req(0, 4'd0, 32'd1, 32'd2);
    wait_grant(g);
    check("rexec_grant", g, 4'b0001);
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rexec_rsp_valid", rsp_valid, 1'b0);
    check("rexec_alu_in1", alu_input1, 32'd0);
    for (int i = 0; i < 4; i++) set_req(i, 4'd0, 32'd1, 32'd2);
    #1 check("rexec_first_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(lat);
    check("rexec_id", rsp_id, 2'd0);
    check("rexec_result", rsp_result, 32'd3);

    // Requesters 1 and 3 held valid: alternate under round-robin, 1 always under fixed priority
    @(posedge clk);
    #1 set_req(1, 4'd5, 32'd7, 32'd3);
    set_req(3, 4'd4, 32'hFFFF_FFFF, 32'd0);
    for (int n = 0; n < 4; n++) begin
      exp_g = (FIXED || (n % 2 == 0)) ? 4'b0010 : 4'b1000;
      wait_grant(g);
      check("prio_grant", g, exp_g);
      wait_rsp(lat);
      check("prio_id", rsp_id, (exp_g == 4'b0010) ? 2'd1 : 2'd3);
      check("prio_result", rsp_result, (exp_g == 4'b0010) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1 req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one combinational 32-bit ALU (ops ADD/SUB/AND/OR/SGE/SGT; carry/zero/sign flags) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready request per requester, single registered response channel tagged with requester ID.
- Sits between the requesting datapath stages and one external ALU instance. The block drives the ALU and captures its outputs.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 32: operand/result width; must match the ALU instance.
- ID_W, 2: requester ID width, ≥ clog2(NUM_REQ).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- req_opcode  input  NUM_REQ*4  flattened opcodes; requester i at [4i+3:4i]
- req_a  input  NUM_REQ*WIDTH  flattened operand 1
- req_b  input  NUM_REQ*WIDTH  flattened operand 2
- alu_opcode  output  4  to ALU opcode
- alu_input1  output  WIDTH  to ALU input1
- alu_input2  output  WIDTH  to ALU input2
- alu_shift  output  5  to ALU shiftValue; constant 0
- alu_result  input  WIDTH  from ALU
- alu_carry, alu_zero, alu_sign  input  1 each  from ALU flags
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accept
- rsp_id  output  ID_W  index of the requester served
- rsp_result  output  WIDTH  captured result
- rsp_carry, rsp_zero, rsp_sign  output  1 each  captured flags
- rsp_err  output  1  illegal opcode (>5)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, all rsp_* outputs 0, req_ready=0. alu_* outputs are driven from zeroed operand registers.
- FSM states:
  - IDLE: if any req_valid, grant the first set bit scanning from rr_ptr upward with wrap. req_ready[grant]=1 combinationally in this cycle only. Latch opcode/a/b/id. rr_ptr <= grant+1 mod NUM_REQ. Next state EXEC. With no valid, stay in IDLE and keep rr_ptr.
  - EXEC: alu_* driven from the latched registers. At the clock edge, capture alu_result and flags into rsp_*. rsp_valid <= 1. Next state RESP.
  - RESP: hold all rsp_* stable while rsp_valid=1 and rsp_ready=0. On rsp_valid&&rsp_ready, rsp_valid <= 0 and go to IDLE.
- req_ready is 0 in EXEC and RESP. A requester's inputs must stay stable while its req_valid is high until accepted.
- Latency: accept at edge T; rsp_valid high after edge T+1 (second cycle). Minimum 3 cycles per op including the response handshake.
- alu_* outputs change only at the IDLE→EXEC edge, so the ALU is stable for a full cycle.
- Illegal opcode (6..15): request is accepted normally. Response has rsp_err=1 and rsp_result=0 with carry/zero/sign all 0; ALU outputs are ignored.
- Legal opcodes: rsp_err=0; result and flags are passed through exactly as the ALU returns them.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait with valid held.
- Dropped request: a req_valid deasserted before grant is simply not served.
- Reset mid-operation (EXEC/RESP): the pending op is dropped and no response is issued. rr_ptr returns to 0.

Optional Feature:
- Macro: ALU_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index wins and rr_ptr is removed.
- Undefined: round-robin as above.

Decomposition:
- Shared package alu_sched_pkg:
  - opcode localparams ADD=0, SUB=1, AND=2, OR=3, SGE=4, SGT=5 and OPC_MAX=5;
  - FSM state encoding IDLE/EXEC/RESP;
  - function is_legal_op.
- One sub-module: alu_rr_arbiter. Combinational grant from req vector and rr_ptr; outputs a one-hot grant plus an encoded index. It holds the macro switch.

Test Plan:
- Single request: requester 2 sends ADD 0xFFFFFFFF+1 → accepted in IDLE; rsp 2 cycles later with id=2, result=0, carry=1, zero=1, sign=0.
- Contention: all 4 valid continuously with SUB 5-3 → grants in order 0,1,2,3,0; each rsp result=2; no requester starved.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_* held stable; all req_ready=0; the next accept occurs only after the handshake.
- Illegal opcode 9 from requester 1 → rsp_err=1, result=0, flags 0, id=1.
- Reset asserted in EXEC → next cycle rsp_valid=0, state IDLE, rr_ptr=0; first grant after reset goes to requester 0.
- With ALU_SCHED_FIXED_PRIO_EN, requesters 1 and 3 continuously valid → requester 1 granted every time.
